// File: rtl/rf_wq_pkg.sv
// Shared types for the register-file write queue.
// Entries carry up to RF_ADDR_W address bits; narrower addresses are zero-extended.
package rf_wq_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 6;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } rf_wq_entry_t;

endpackage

// File: rtl/rf_write_queue_if.sv
// Producer handshakes, decode read/bypass lines and register-file write port of the write queue.
interface rf_write_queue_if
    import rf_wq_pkg::*;
#(
    parameter int addr_width_p = RF_ADDR_W,
    parameter int depth_p      = 4
);

    logic                    ld_v_i;
    logic [addr_width_p-1:0] ld_addr_i;
    logic [RF_DATA_W-1:0]    ld_data_i;
    logic                    ld_ready_o;

    logic                    alu_v_i;
    logic [addr_width_p-1:0] alu_addr_i;
    logic [RF_DATA_W-1:0]    alu_data_i;
    logic                    alu_ready_o;

    logic [addr_width_p-1:0] rs_addr_i;
    logic [addr_width_p-1:0] rd_addr_i;
    logic [RF_DATA_W-1:0]    rf_rs_val_i;
    logic [RF_DATA_W-1:0]    rf_rd_val_i;
    logic [RF_DATA_W-1:0]    rs_val_o;
    logic [RF_DATA_W-1:0]    rd_val_o;

    logic                    wen_o;
    logic [RF_DATA_W-1:0]    wa_o;
    logic [RF_DATA_W-1:0]    write_data_o;
    logic [$clog2(depth_p):0] count_o;

    modport master (
        output ld_v_i, ld_addr_i, ld_data_i,
        output alu_v_i, alu_addr_i, alu_data_i,
        output rs_addr_i, rd_addr_i, rf_rs_val_i, rf_rd_val_i,
        input  ld_ready_o, alu_ready_o, rs_val_o, rd_val_o,
        input  wen_o, wa_o, write_data_o, count_o
    );

    modport slave (
        input  ld_v_i, ld_addr_i, ld_data_i,
        input  alu_v_i, alu_addr_i, alu_data_i,
        input  rs_addr_i, rd_addr_i, rf_rs_val_i, rf_rd_val_i,
        output ld_ready_o, alu_ready_o, rs_val_o, rd_val_o,
        output wen_o, wa_o, write_data_o, count_o
    );

endinterface

// File: rtl/rf_wq_bypass.sv
// Newest-match search over the queued writes for one read address;
// falls back to the raw register-file value when nothing pending matches.
module rf_wq_bypass
    import rf_wq_pkg::*;
#(
    parameter int depth_p = 4
) (
    input  rf_wq_entry_t           i_entries [depth_p],
    input  logic [$clog2(depth_p)-1:0] i_head,
    input  logic [$clog2(depth_p):0]   i_count,
    input  logic [RF_ADDR_W-1:0]   i_addr,
    input  logic [RF_DATA_W-1:0]   i_rf_val,
    output logic [RF_DATA_W-1:0]   o_val
);

    localparam int PTR_W = $clog2(depth_p);

    logic [PTR_W-1:0] w_idx;

    // Walk oldest to newest so the last match, i.e. the newest one, wins.
    always_comb begin
        o_val = i_rf_val;
        w_idx = i_head;
        for (int unsigned i = 0; i < depth_p; i++) begin
            w_idx = i_head + PTR_W'(i);
            if ((i < 32'(i_count)) && (i_entries[w_idx].addr == i_addr)) begin
                o_val = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/rf_write_queue.sv
// Two-producer ordered write queue in front of the register file's single write port,
// draining one entry per cycle and bypassing pending writes to the decode read ports.
module rf_write_queue
    import rf_wq_pkg::*;
#(
    parameter int addr_width_p = RF_ADDR_W,
    parameter int depth_p      = 4
) (
    input  logic             clk,
    input  logic             reset_n_i,
    rf_write_queue_if.slave  bus
);

    localparam int PTR_W = $clog2(depth_p);
    localparam int CNT_W = PTR_W + 1;

    if (addr_width_p > RF_ADDR_W || depth_p < 2 || (depth_p & (depth_p - 1)) != 0) begin : g_bad_cfg
        $error("rf_write_queue: unsupported addr_width_p/depth_p");
    end

    rf_wq_entry_t     r_mem [depth_p];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;

    logic             w_drain;
    logic [CNT_W-1:0] w_free;
    logic             w_acc_ld;
    logic             w_acc_alu;
    logic [PTR_W-1:0] w_alu_slot;
    rf_wq_entry_t     w_ld_ent;
    rf_wq_entry_t     w_alu_ent;
    rf_wq_entry_t     w_head_ent;
    logic [RF_ADDR_W-1:0] w_rs_addr;
    logic [RF_ADDR_W-1:0] w_rd_addr;

    // The head retiring this cycle frees its slot for an incoming request.
    assign w_drain = (r_count != '0);
    assign w_free  = CNT_W'(depth_p) - r_count + CNT_W'(w_drain);

    assign bus.ld_ready_o  = (w_free >= CNT_W'(1));
    assign bus.alu_ready_o = (w_free >= CNT_W'(2)) || ((w_free == CNT_W'(1)) && !bus.ld_v_i);

    assign w_acc_ld   = bus.ld_v_i && bus.ld_ready_o;
    assign w_acc_alu  = bus.alu_v_i && bus.alu_ready_o;
    assign w_alu_slot = r_tail + PTR_W'(w_acc_ld);

    always_comb begin
        w_ld_ent       = '0;
        w_ld_ent.addr  = RF_ADDR_W'(bus.ld_addr_i);
        w_ld_ent.data  = bus.ld_data_i;
        w_alu_ent      = '0;
        w_alu_ent.addr = RF_ADDR_W'(bus.alu_addr_i);
        w_alu_ent.data = bus.alu_data_i;
    end

    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_drain);
            r_tail  <= r_tail + PTR_W'(w_acc_ld) + PTR_W'(w_acc_alu);
            r_count <= r_count + CNT_W'(w_acc_ld) + CNT_W'(w_acc_alu) - CNT_W'(w_drain);
        end
    end

    // Storage needs no reset: slots are only observed while counted as occupied.
    always_ff @(posedge clk) begin
        if (w_acc_ld) begin
            r_mem[r_tail] <= w_ld_ent;
        end
        if (w_acc_alu) begin
            r_mem[w_alu_slot] <= w_alu_ent;
        end
    end

    assign w_head_ent       = r_mem[r_head];
    assign bus.wen_o        = w_drain;
    assign bus.wa_o         = w_drain ? RF_DATA_W'(w_head_ent.addr) : '0;
    assign bus.write_data_o = w_drain ? w_head_ent.data : '0;
    assign bus.count_o      = r_count;

    assign w_rs_addr = RF_ADDR_W'(bus.rs_addr_i);
    assign w_rd_addr = RF_ADDR_W'(bus.rd_addr_i);

    rf_wq_bypass #(.depth_p(depth_p)) u_rs_bypass (
        .i_entries (r_mem),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_addr    (w_rs_addr),
        .i_rf_val  (bus.rf_rs_val_i),
        .o_val     (bus.rs_val_o)
    );

    rf_wq_bypass #(.depth_p(depth_p)) u_rd_bypass (
        .i_entries (r_mem),
        .i_head    (r_head),
        .i_count   (r_count),
        .i_addr    (w_rd_addr),
        .i_rf_val  (bus.rf_rd_val_i),
        .o_val     (bus.rd_val_o)
    );

endmodule

// File: tb/tb_rf_write_queue.sv
// Scoreboard bench for rf_write_queue: a queue of expected writes plus a reference
// register file predict every drain, bypass value, occupancy and ready.
module tb_rf_write_queue;

    localparam int AW    = 6;
    localparam int DEPTH = 4;
    localparam int NREG  = 64;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic clk = 1'b0;
    logic reset_n_i = 1'b0;
    always #5 clk = ~clk;

    rf_write_queue_if #(.addr_width_p(AW), .depth_p(DEPTH)) bus ();

    rf_write_queue #(.addr_width_p(AW), .depth_p(DEPTH)) dut (
        .clk       (clk),
        .reset_n_i (reset_n_i),
        .bus       (bus)
    );

    wr_t         exp_q[$];
    logic [31:0] rf_mem [NREG];
    logic [31:0] ref_rf [NREG];
    int          n_checks = 0;
    int          n_fail = 0;
    int          max_cnt = 0;
    bit          alu_bp_seen = 1'b0;

    // Environment register file: asynchronous read, synchronous write.
    assign bus.rf_rs_val_i = rf_mem[bus.rs_addr_i];
    assign bus.rf_rd_val_i = rf_mem[bus.rd_addr_i];
    always @(posedge clk) begin
        if (bus.wen_o) rf_mem[bus.wa_o[AW-1:0]] <= bus.write_data_o;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [AW-1:0] a);
        for (int i = int'(exp_q.size()) - 1; i >= 0; i--) begin
            if (exp_q[i].a == a) return exp_q[i].d;
        end
        return ref_rf[a];
    endfunction

    // Monitor: every cycle out of reset the DUT must present exactly the oldest pending write.
    always @(negedge clk) begin : monitor
        wr_t e;
        if (reset_n_i) begin
            check("count", 32'(bus.count_o), 32'(exp_q.size()));
            check("rs_bypass", bus.rs_val_o, model_read(bus.rs_addr_i));
            check("rd_bypass", bus.rd_val_o, model_read(bus.rd_addr_i));
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wen", 32'(bus.wen_o), 32'd1);
                check("wa", bus.wa_o, 32'(e.a));
                check("wdata", bus.write_data_o, e.d);
                ref_rf[e.a] = e.d;
            end else begin
                check("wen_idle", 32'(bus.wen_o), 32'd0);
                check("wa_idle", bus.wa_o, 32'd0);
                check("wdata_idle", bus.write_data_o, 32'd0);
            end
        end
    end

    // One cycle of stimulus; expected acceptances are pushed before the edge that takes them.
    task automatic cycle(input bit lv, input logic [AW-1:0] la, input logic [31:0] ldd,
                         input bit av, input logic [AW-1:0] aa, input logic [31:0] ad,
                         input logic [AW-1:0] rs, input logic [AW-1:0] rd);
        int  free;
        bit  exp_ldr;
        bit  exp_alur;
        @(negedge clk);
        #1;
        bus.ld_v_i     = lv;
        bus.ld_addr_i  = la;
        bus.ld_data_i  = ldd;
        bus.alu_v_i    = av;
        bus.alu_addr_i = aa;
        bus.alu_data_i = ad;
        bus.rs_addr_i  = rs;
        bus.rd_addr_i  = rd;
        #1;
        free     = DEPTH - int'(exp_q.size());
        exp_ldr  = (free >= 1);
        exp_alur = (free >= 2) || (free == 1 && !lv);
        check("ld_ready", 32'(bus.ld_ready_o), 32'(exp_ldr));
        check("alu_ready", 32'(bus.alu_ready_o), 32'(exp_alur));
        if (bus.ld_ready_o && !bus.alu_ready_o) alu_bp_seen = 1'b1;
        if (int'(bus.count_o) > max_cnt) max_cnt = int'(bus.count_o);
        if (lv && exp_ldr) exp_q.push_back('{a: la, d: ldd});
        if (av && exp_alur) exp_q.push_back('{a: aa, d: ad});
    endtask

    task automatic idle(input logic [AW-1:0] rs, input logic [AW-1:0] rd);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, rs, rd);
    endtask

    initial begin
        for (int i = 0; i < NREG; i++) begin
            rf_mem[i] = $urandom;
            ref_rf[i] = rf_mem[i];
        end
        bus.ld_v_i = 1'b0;  bus.ld_addr_i = '0;  bus.ld_data_i = '0;
        bus.alu_v_i = 1'b0; bus.alu_addr_i = '0; bus.alu_data_i = '0;
        bus.rs_addr_i = 6'd7; bus.rd_addr_i = 6'd9;

        // Reset state
        #12;
        check("rst_wen", 32'(bus.wen_o), 32'd0);
        check("rst_wa", bus.wa_o, 32'd0);
        check("rst_wdata", bus.write_data_o, 32'd0);
        check("rst_count", 32'(bus.count_o), 32'd0);
        check("rst_ld_ready", 32'(bus.ld_ready_o), 32'd1);
        check("rst_alu_ready", 32'(bus.alu_ready_o), 32'd1);
        check("rst_rs_pass", bus.rs_val_o, ref_rf[7]);
        check("rst_rd_pass", bus.rd_val_o, ref_rf[9]);
        @(negedge clk);
        #3 reset_n_i = 1'b1;

        // Single ALU write, then same-register ld/alu pair
        cycle(1'b0, '0, '0, 1'b1, 6'd5, 32'h0000_00AA, 6'd5, 6'd0);
        idle(6'd5, 6'd0); idle(6'd5, 6'd0); idle(6'd5, 6'd0);
        cycle(1'b1, 6'd3, 32'h11, 1'b1, 6'd3, 32'h22, 6'd3, 6'd3);
        idle(6'd3, 6'd3); idle(6'd3, 6'd3); idle(6'd3, 6'd3);

        // Duplicate address fill and probes, then pass-through probe
        cycle(1'b1, 6'd1, 32'h1, 1'b1, 6'd2, 32'h2, 6'd1, 6'd2);
        cycle(1'b1, 6'd1, 32'h3, 1'b1, 6'd4, 32'h4, 6'd1, 6'd2);
        idle(6'd1, 6'd2); idle(6'd1, 6'd2);
        idle(6'd9, 6'd4); idle(6'd9, 6'd4); idle(6'd9, 6'd4);

        // Sustained dual-producer traffic
        for (int k = 0; k < 16; k++) begin
            cycle(1'b1, AW'(k), $urandom, 1'b1, AW'(k + 32), $urandom, AW'(k), AW'(k + 31));
        end
        for (int k = 0; k < 8; k++) idle(AW'(k + 10), AW'(k + 40));
        check("sat_count_max", 32'(max_cnt), 32'(DEPTH));
        check("alu_backpressure", 32'(alu_bp_seen), 32'd1);

        // Wrap-around with back-to-back single ALU writes
        for (int k = 0; k < 3 * DEPTH; k++) begin
            cycle(1'b0, '0, '0, 1'b1, AW'(20 + (k % 5)), $urandom, AW'(20 + (k % 5)), AW'($urandom_range(0, 63)));
        end
        for (int k = 0; k < 6; k++) idle(AW'(20 + k), AW'(24));

        // Random traffic with heavy address reuse
        for (int k = 0; k < 300; k++) begin
            cycle(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), $urandom,
                  AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
        end
        for (int k = 0; k < 8; k++) idle(AW'(k), AW'(k + 1));

        // Asynchronous reset with three entries pending
        cycle(1'b1, 6'd11, 32'hA1, 1'b1, 6'd12, 32'hA2, 6'd11, 6'd12);
        cycle(1'b1, 6'd11, 32'hA3, 1'b1, 6'd14, 32'hA4, 6'd11, 6'd12);
        @(posedge clk);
        #2;
        reset_n_i = 1'b0;
        bus.ld_v_i = 1'b0;
        bus.alu_v_i = 1'b0;
        #1;
        check("async_rst_wen", 32'(bus.wen_o), 32'd0);
        check("async_rst_count", 32'(bus.count_o), 32'd0);
        check("async_rst_wa", bus.wa_o, 32'd0);
        exp_q.delete();
        @(negedge clk);
        #3 reset_n_i = 1'b1;
        for (int k = 0; k < 5; k++) idle(6'd12, 6'd14);

        for (int i = 0; i < NREG; i++) check("rf_final", rf_mem[i], ref_rf[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rf_write_queue.md
# rf_write_queue

Write-side front end for the 32-bit register file, sitting between the execute/load stages and the register file's single synchronous write port. It accepts write requests from two producers (ALU result path and load-return path) with valid/ready handshakes and buffers them in an ordered queue. It drains at most one entry per cycle into the register file. The decode-stage read values are bypassed with the newest pending queued write, so readers never see stale data.

## Interface
Parameters:
- addr_width_p, 6, register address width; the register file has 2**addr_width_p entries
- depth_p, 4, queue entries; power of two, at least 2

Ports:
- clk  in  1  single clock; all state updates on posedge
- reset_n_i  in  1  asynchronous, active-low reset
- ld_v_i  in  1  load-return write request valid
- ld_addr_i  in  addr_width_p  load destination register
- ld_data_i  in  32  load write data
- ld_ready_o  out  1  load request accepted this cycle when high with ld_v_i
- alu_v_i  in  1  ALU write request valid
- alu_addr_i  in  addr_width_p  ALU destination register
- alu_data_i  in  32  ALU write data
- alu_ready_o  out  1  ALU request accepted this cycle when high with alu_v_i
- rs_addr_i, rd_addr_i  in  addr_width_p each  decode-stage read addresses, also driven to the register file
- rf_rs_val_i, rf_rd_val_i  in  32 each  raw asynchronous read data from the register file
- rs_val_o, rd_val_o  out  32 each  bypassed read data to decode
- wen_o  out  1  register file write enable
- wa_o  out  32  register file write address, zero-extended from addr_width_p
- write_data_o  out  32  register file write data
- count_o  out  $clog2(depth_p)+1  current occupancy

## Operation
- The queue is a circular FIFO of {addr, data} entries, with head and tail pointers of $clog2(depth_p) bits that wrap modulo depth_p, plus a count.
- Drain: when count != 0, wen_o=1, wa_o/write_data_o = head entry, and the head retires at the clock edge. When count == 0, wen_o=0, and wa_o and write_data_o are 0.
- Space: free = depth_p - count + (count != 0). The same-cycle dequeue is credited.
- ld_ready_o = (free >= 1).
- alu_ready_o = (free >= 2) or (free == 1 and !ld_v_i).
- Ordering: when both producers are accepted in the same cycle, the load entry is enqueued first (older), then the ALU entry. The queue can therefore take two entries per cycle.
- Occupancy update: count_next = count + accepted_ld + accepted_alu - (count != 0).
- Bypass, evaluated independently for rs and rd:
  - Scan the valid entries from newest (tail-1) to oldest (head).
  - The first entry whose addr equals the read address drives the output.
  - If no entry matches, the output passes rf_*_val_i.
  - The head entry being written this cycle still participates.
  - Requests arriving this cycle are not forwarded.
- Duplicate addresses in the queue are legal. Writes retire in order, so the register file ends with the newest value.
- Address 0 gets no special treatment.

## Timing
- Reset (asynchronous, immediate): head=tail=count=0, so wen_o=0, wa_o=0, write_data_o=0, count_o=0, ld_ready_o=1, alu_ready_o=1, and the bypass outputs pass the register file values.
- Reset asserted mid-operation discards all pending writes; no partial write is issued.
- A request accepted at edge N into an empty queue appears on wen_o during cycle N+1 and is in the register file after edge N+1.
- Bypass covers the address from cycle N+1 onward, so there is no visibility gap.
- ready outputs depend combinationally on registered count and, for alu_ready_o, on ld_v_i. No other input-to-ready path exists.
- Throughput is one retirement per cycle. Sustained dual-producer traffic fills the queue and backpressures the ALU first.
- Full queue (count == depth_p): free=1, so the load can still enter in the slot freed by the same-cycle drain.

## Structure
- Package rf_wq_pkg:
  - rf_wq_entry_t packed struct {addr[addr_width_p-1:0], data[31:0]}
  - RF_DATA_W=32 constant
- Sub-module rf_wq_bypass: combinational newest-match search over the entry array using head and count; instantiated twice (rs, rd).
- FIFO pointers, count, and the handshake logic stay in the top module.

## Test plan
- Reset, then ALU write r5=0x0000_00AA at edge 1 → cycle 2: wen_o=1, wa_o=5, write_data_o=0xAA; rs_addr_i=5 gives rs_val_o=0xAA in cycle 2; count_o returns to 0 in cycle 3.
- Same-cycle ld r3=0x11 and alu r3=0x22 into an empty queue → writes issue in order 0x11 then 0x22; rs_val_o for r3 = 0x22 during both drain cycles.
- Hold alu_v_i and ld_v_i high continuously with distinct addresses → count_o saturates at depth_p; alu_ready_o drops while ld_ready_o stays 1; no request is lost or duplicated (scoreboard check against a reference register model).
- Fill with r1=0x1, r2=0x2, r1=0x3, r4=0x4; probe rs=r1 and rd=r2 → rs_val_o=0x3, rd_val_o=0x2; probe r9 → rf_rs_val_i is passed through.
- Assert reset_n_i asynchronously mid-cycle with 3 entries queued → wen_o and count_o go to 0 immediately with no clock edge; no further writes after release.
- Wrap-around: 3×depth_p back-to-back single ALU writes → pointers wrap cleanly; the register file contents match the reference model.
